// File: rtl/cuca_pkg.sv
// Shared types for the ALU and the operation sequencer that drives it.
//   alu_op_t    : op code seen by the two-register ALU
//   seq_op_t    : arithmetic request accepted by alu_seq
//   seq_state_t : alu_seq micro-sequence states
//   BITW_DEF    : default datapath / bus width
//   exec_op()   : maps a request op to the ALU op issued in the execute cycle
package cuca_pkg;

  localparam int BITW_DEF = 8;

  typedef enum logic [2:0] {
    ALU_NOP      = 3'd0,
    ALU_WRITE_R0 = 3'd1,
    ALU_WRITE_R1 = 3'd2,
    ALU_READ_R0  = 3'd3,
    ALU_ADD      = 3'd4,
    ALU_SUB      = 3'd5,
    ALU_INC      = 3'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    SEQ_ADD = 2'd0,
    SEQ_SUB = 2'd1,
    SEQ_INC = 2'd2,
    SEQ_RDA = 2'd3
  } seq_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_CAPT   = 3'd4,
    S_RESP   = 3'd5
  } seq_state_t;

  function automatic alu_op_t exec_op(input seq_op_t op);
    case (op)
      SEQ_ADD: exec_op = ALU_ADD;
      SEQ_SUB: exec_op = ALU_SUB;
      SEQ_INC: exec_op = ALU_INC;
      default: exec_op = ALU_READ_R0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request / response handshake bundle of alu_seq.
//   req_valid/req_ready : request handshake, carries req_op, req_a, req_b
//   rsp_valid/rsp_ready : response handshake, carries rsp_data
// master = requester side, slave = alu_seq side.
interface alu_seq_if
  import cuca_pkg::*;
#(
  parameter int BITW = BITW_DEF
);
  logic            req_valid;
  logic            req_ready;
  seq_op_t         req_op;
  logic [BITW-1:0] req_a;
  logic [BITW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITW-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_seq_tri_buf.sv
// Tri-state bus driver.
//   i_data : value to place on the bus
//   i_rw   : output enable; 0 releases the bus (high impedance)
//   o_bus  : tri-state bus
module tri_buf #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rw,
  output wire  [WIDTH-1:0] o_bus
);
  assign o_bus = i_rw ? i_data : {WIDTH{1'bz}};
endmodule

// File: rtl/alu_seq.sv
// Operation sequencer in front of the two-register ALU.
// Takes one (op, A, B) request, runs load R0 / load R1 / execute / capture
// on the ALU, then offers the result until the consumer takes it.
//   clock  : rising edge for all state, falling edge for result capture only
//   reset  : synchronous, active high
//   s      : alu_seq_if.slave request/response handshakes
//   alu_op : op code to the ALU
//   busy   : high whenever not idle
//   bus    : shared tri-state data bus to the ALU
module alu_seq
  import cuca_pkg::*;
#(
  parameter int BITW = BITW_DEF
) (
  input  logic           clock,
  input  logic           reset,
  alu_seq_if.slave       s,
  output alu_op_t        alu_op,
  output logic           busy,
  inout  wire [BITW-1:0] bus
);

  seq_state_t      r_state;
  seq_op_t         r_op;
  logic [BITW-1:0] r_a;
  logic [BITW-1:0] r_b;
  logic [BITW-1:0] r_rsp_data;

  alu_op_t         w_alu_op;
  logic            w_bus_oe;
  logic [BITW-1:0] w_bus_data;

  // Sequencer: operands are only latched on an accepted request, so they
  // carry no reset of their own.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s.req_valid) begin
            r_op    <= s.req_op;
            r_a     <= s.req_a;
            r_b     <= s.req_b;
            r_state <= S_LOAD_A;
          end
        end
        S_LOAD_A: r_state <= S_LOAD_B;
        S_LOAD_B: r_state <= S_EXEC;
        S_EXEC:   r_state <= S_CAPT;
        S_CAPT:   r_state <= S_RESP;
        S_RESP: begin
          if (s.rsp_ready) r_state <= S_IDLE;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Op code and bus enable decode. Gating with reset releases the bus and
  // quiets the ALU in the very cycle reset is sampled.
  always_comb begin
    w_alu_op   = ALU_NOP;
    w_bus_oe   = 1'b0;
    w_bus_data = r_a;
    if (!reset) begin
      case (r_state)
        S_LOAD_A: begin
          w_alu_op   = ALU_WRITE_R0;
          w_bus_oe   = 1'b1;
          w_bus_data = r_a;
        end
        S_LOAD_B: begin
          w_alu_op   = ALU_WRITE_R1;
          w_bus_oe   = 1'b1;
          w_bus_data = r_b;
        end
        S_EXEC:  w_alu_op = exec_op(r_op);
        default: ;
      endcase
    end
  end

  // The ALU drives its result only while clock is high in S_CAPT, so the
  // result is taken on the falling edge of that cycle. Outside S_CAPT the
  // bus is never sampled.
  always_ff @(negedge clock) begin
    if (reset) begin
      r_rsp_data <= '0;
    end else if (r_state == S_CAPT) begin
      r_rsp_data <= bus;
    end
  end

  tri_buf #(.WIDTH(BITW)) u_bus_drv (
    .i_data (w_bus_data),
    .i_rw   (w_bus_oe),
    .o_bus  (bus)
  );

  assign alu_op      = w_alu_op;
  assign busy        = (r_state != S_IDLE);
  assign s.req_ready = !reset && (r_state == S_IDLE);
  assign s.rsp_valid = !reset && (r_state == S_RESP);
  assign s.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import cuca_pkg::*;

  localparam int BITW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_seq_if #(.BITW(BITW)) sif ();
  alu_op_t         alu_op;
  logic            busy;
  wire  [BITW-1:0] bus;

  alu_seq #(.BITW(BITW)) dut (
    .clock  (clock),
    .reset  (reset),
    .s      (sif),
    .alu_op (alu_op),
    .busy   (busy),
    .bus    (bus)
  );

  // Two-register ALU model: samples op/bus mid-cycle, acts on the rising
  // edge, drives an execute result during the following clock-high phase.
  logic [BITW-1:0] alu_r0, alu_r1, alu_drv, bus_s;
  logic            alu_oe, rst_s;
  alu_op_t         op_s;
  assign bus = alu_oe ? alu_drv : {BITW{1'bz}};

  initial begin
    alu_oe = 1'b0; alu_drv = '0; alu_r0 = '0; alu_r1 = '0;
    op_s = ALU_NOP; bus_s = '0; rst_s = 1'b1;
  end

  always @(negedge clock) begin
    op_s  = alu_op;
    bus_s = bus;
    rst_s = reset;
  end

  always @(negedge clock) begin
    #1;
    alu_oe = 1'b0;
  end

  always @(posedge clock) begin
    if (rst_s) begin
      alu_r0 = '0; alu_r1 = '0; alu_oe = 1'b0;
    end else begin
      case (op_s)
        ALU_WRITE_R0: alu_r0 = bus_s;
        ALU_WRITE_R1: alu_r1 = bus_s;
        ALU_ADD:      begin alu_drv = alu_r0 + alu_r1;  alu_oe = 1'b1; end
        ALU_SUB:      begin alu_drv = alu_r0 - alu_r1;  alu_oe = 1'b1; end
        ALU_INC:      begin alu_drv = alu_r1 + 8'd1;    alu_oe = 1'b1; end
        ALU_READ_R0:  begin alu_drv = alu_r0;           alu_oe = 1'b1; end
        default: ;
      endcase
    end
  end

  // Reference: result of a request by plain modulo-256 arithmetic.
  function automatic logic [BITW-1:0] ref_res(input seq_op_t op,
                                              input logic [BITW-1:0] a,
                                              input logic [BITW-1:0] b);
    int r;
    case (op)
      SEQ_ADD: r = int'(a) + int'(b);
      SEQ_SUB: r = int'(a) - int'(b);
      SEQ_INC: r = int'(b) + 1;
      default: r = int'(a);
    endcase
    return BITW'(r % 256 + 256);
  endfunction

  function automatic alu_op_t ref_exec(input seq_op_t op);
    case (op)
      SEQ_ADD: return ALU_ADD;
      SEQ_SUB: return ALU_SUB;
      SEQ_INC: return ALU_INC;
      default: return ALU_READ_R0;
    endcase
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One request with hold = number of response cycles with rsp_ready low.
  task automatic run_txn(input seq_op_t op, input logic [BITW-1:0] a,
                         input logic [BITW-1:0] b, input logic [BITW-1:0] exp,
                         input int hold, input string tag);
    int w;
    w = 0;
    while (!sif.req_ready && w < 20) begin
      tick();
      w++;
    end
    chk({tag, " req_ready idle"}, 32'(sif.req_ready), 32'd1);
    sif.req_valid = 1'b1;
    sif.req_op    = op;
    sif.req_a     = a;
    sif.req_b     = b;
    sif.rsp_ready = (hold == 0);
    tick();
    sif.req_valid = 1'b0;
    chk({tag, " op load_a"}, 32'(alu_op), 32'(ALU_WRITE_R0));
    chk({tag, " bus a"}, 32'(bus), 32'(a));
    chk({tag, " req_ready busy"}, 32'(sif.req_ready), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, " op load_b"}, 32'(alu_op), 32'(ALU_WRITE_R1));
    chk({tag, " bus b"}, 32'(bus), 32'(b));
    tick();
    chk({tag, " op exec"}, 32'(alu_op), 32'(ref_exec(op)));
    chk({tag, " oe exec"}, 32'(dut.w_bus_oe), 32'd0);
    tick();
    chk({tag, " op capt"}, 32'(alu_op), 32'(ALU_NOP));
    chk({tag, " rsp_valid early"}, 32'(sif.rsp_valid), 32'd0);
    tick();
    chk({tag, " rsp_valid"}, 32'(sif.rsp_valid), 32'd1);
    chk({tag, " rsp_data"}, 32'(sif.rsp_data), 32'(exp));
    for (int i = 1; i < hold; i++) begin
      tick();
      chk({tag, " hold valid"}, 32'(sif.rsp_valid), 32'd1);
      chk({tag, " hold data"}, 32'(sif.rsp_data), 32'(exp));
      chk({tag, " hold req_ready"}, 32'(sif.req_ready), 32'd0);
    end
    sif.rsp_ready = 1'b1;
    tick();
    chk({tag, " rsp_valid done"}, 32'(sif.rsp_valid), 32'd0);
    chk({tag, " req_ready done"}, 32'(sif.req_ready), 32'd1);
    chk({tag, " busy done"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    seq_op_t         op;
    logic [BITW-1:0] a;
    logic [BITW-1:0] b;
    logic [BITW-1:0] exp;
    string           name;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc[$];
    logic [BITW-1:0] got[$];
    seq_op_t rop;
    logic [BITW-1:0] ra, rb;

    vecs[0] = '{SEQ_ADD, 8'h12, 8'h34, 8'h46, "add"};
    vecs[1] = '{SEQ_SUB, 8'h10, 8'h20, 8'hF0, "sub_neg"};
    vecs[2] = '{SEQ_SUB, 8'h20, 8'h20, 8'h00, "sub_zero"};
    vecs[3] = '{SEQ_INC, 8'h55, 8'hFF, 8'h00, "inc_wrap"};
    vecs[4] = '{SEQ_RDA, 8'hA5, 8'h00, 8'hA5, "rda"};

    sif.req_valid = 1'b0; sif.req_op = SEQ_ADD; sif.req_a = '0; sif.req_b = '0;
    sif.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst req_ready", 32'(sif.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(sif.rsp_valid), 32'd0);
    chk("rst rsp_data", 32'(sif.rsp_data), 32'd0);
    chk("rst alu_op", 32'(alu_op), 32'(ALU_NOP));
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bus oe", 32'(dut.w_bus_oe), 32'd0);

    foreach (vecs[i]) run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, vecs[i].name);

    run_txn(SEQ_ADD, 8'h01, 8'h02, 8'h03, 3, "backpressure");

    // Reset while executing.
    sif.req_valid = 1'b1; sif.req_op = SEQ_ADD; sif.req_a = 8'h05; sif.req_b = 8'h06;
    sif.rsp_ready = 1'b1;
    tick();
    sif.req_valid = 1'b0;
    tick();
    tick();
    chk("midrst exec op", 32'(alu_op), 32'(ALU_ADD));
    reset = 1'b1;
    #1;
    chk("midrst alu_op nop", 32'(alu_op), 32'(ALU_NOP));
    chk("midrst oe", 32'(dut.w_bus_oe), 32'd0);
    chk("midrst rsp_valid", 32'(sif.rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("postrst req_ready", 32'(sif.req_ready), 32'd1);
    chk("postrst rsp_valid", 32'(sif.rsp_valid), 32'd0);
    chk("postrst busy", 32'(busy), 32'd0);
    chk("postrst oe", 32'(dut.w_bus_oe), 32'd0);
    run_txn(SEQ_ADD, 8'h07, 8'h08, 8'h0F, 0, "after_rst");

    // Back-to-back with req_valid held high.
    sif.req_valid = 1'b1; sif.req_op = SEQ_ADD; sif.req_a = 8'h01; sif.req_b = 8'h01;
    sif.rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      logic acc;
      acc = sif.req_valid && sif.req_ready;
      if (acc) acc_cyc.push_back(c);
      if (sif.rsp_valid && sif.rsp_ready) got.push_back(sif.rsp_data);
      tick();
      if (acc && acc_cyc.size() == 1) begin
        sif.req_a = 8'h02; sif.req_b = 8'h03;
      end else if (acc) begin
        sif.req_valid = 1'b0;
      end
    end
    chk("b2b accepts", 32'(acc_cyc.size()), 32'd2);
    chk("b2b resps", 32'(got.size()), 32'd2);
    if (acc_cyc.size() == 2) chk("b2b spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    if (got.size() == 2) begin
      chk("b2b data0", 32'(got[0]), 32'h02);
      chk("b2b data1", 32'(got[1]), 32'h05);
    end
    sif.req_valid = 1'b0;
    repeat (2) tick();

    // Randomized requests against the reference model.
    for (int n = 0; n < 30; n++) begin
      rop = seq_op_t'($urandom_range(0, 3));
      ra  = BITW'($urandom);
      rb  = BITW'($urandom);
      run_txn(rop, ra, rb, ref_res(rop, ra, rb), int'($urandom_range(0, 2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Operation sequencer that sits directly upstream of the two-register ALU and owns the ALU's op input and shared data bus.
- Accepts one arithmetic request (op, A, B) over a valid/ready handshake.
- Runs the fixed ALU micro-sequence: load R0, load R1, execute, capture result from the bus.
- Returns the result over a second valid/ready handshake, so upstream logic never has to sequence ALU ops cycle by cycle.

Parameters:
- BITW, 8, datapath and bus width. Must match the ALU instance.

Ports:
- clock  in  1  system clock. Rising edge for all state; falling edge only for result capture.
- reset  in  1  synchronous, active-high. Top level drives the ALU's n_reset with ~reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  seq_op_t (2)  SEQ_ADD, SEQ_SUB, SEQ_INC, SEQ_RDA.
- req_a  in  BITW  operand A, loaded into ALU R0.
- req_b  in  BITW  operand B, loaded into ALU R1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  BITW  result, modulo 2^BITW.
- alu_op  out  alu_op_t  op code to the ALU.
- busy  out  1  high in every state except S_IDLE.
- bus  inout  BITW  shared tri-state bus to the ALU.

Behaviour:
- Reset values:
  - state S_IDLE; req_ready 1 after the reset cycle; rsp_valid 0; rsp_data 0; alu_op ALU_NOP; busy 0; bus released (Z).
- State machine: S_IDLE -> S_LOAD_A -> S_LOAD_B -> S_EXEC -> S_CAPT -> S_RESP -> S_IDLE.
  - S_IDLE: req_ready=1. On a rising edge with req_valid&req_ready, latch req_op/a/b into internal registers and go to S_LOAD_A.
  - S_LOAD_A: alu_op=ALU_WRITE_R0; drive latched A on the bus for the whole cycle.
  - S_LOAD_B: alu_op=ALU_WRITE_R1; drive latched B on the bus for the whole cycle.
  - S_EXEC: alu_op from latched op: SEQ_ADD->ALU_ADD, SEQ_SUB->ALU_SUB, SEQ_INC->ALU_INC (B+1, A ignored), SEQ_RDA->ALU_READ_R0. Bus released.
  - S_CAPT: alu_op=ALU_NOP; bus released.
    - The ALU drives the bus only during the clock-high phase of this cycle.
    - rsp_data captures the bus on the falling edge of clock inside S_CAPT. This is the only negedge register.
  - S_RESP: rsp_valid=1; rsp_data held stable. On a rising edge with rsp_ready, go to S_IDLE.
- Output timing:
  - alu_op and the bus output-enable are combinational decodes of state, stable for the full cycle.
  - The bus is never driven by alu_seq in S_EXEC, S_CAPT, S_RESP or S_IDLE.
- Latency: handshake at edge E0 puts S_LOAD_A in the following cycle. rsp_valid rises 4 edges after E0 (entry to S_RESP). Minimum request-to-request spacing is 6 cycles when rsp_ready is held at 1.
- req_ready is 0 in all states except S_IDLE. There is no request queueing.
- Requests and responses may not overlap: req_ready stays low while rsp_valid is high.
- Arithmetic: all wrap modulo 2^BITW, no carry or borrow output. SUB is A-B; INC is B+1.
- Reset mid-operation: the next state is S_IDLE.
  - The bus is released in the cycle reset is sampled; rsp_valid drops and alu_op becomes ALU_NOP.
  - The ALU resets in the same edge, so no stale drive follows.
  - The in-flight request is discarded with no response.
- An X/Z on the bus outside S_CAPT must not affect rsp_data.

Decomposition:
- Shared package cuca_pkg holds:
  - alu_op_t: the ALU op enum, moved there so the ALU and alu_seq share it.
  - seq_op_t.
  - seq_state_t.
  - The default BITW constant.
- Sub-module: reuse the existing tri_buf (WIDTH=BITW) for the bus driver, rw = bus output-enable.
- Everything else stays flat.

Test Plan:
- BITW=8, ADD a=0x12 b=0x34, rsp_ready=1:
  - alu_op sequence WRITE_R0, WRITE_R1, ADD, NOP.
  - rsp_valid 4 edges after accept; rsp_data=0x46.
- SUB a=0x10 b=0x20 -> 0xF0. SUB a=0x20 b=0x20 -> 0x00.
- INC a=0x55 b=0xFF -> 0x00 (wrap).
- RDA a=0xA5 b=0x00 -> 0xA5.
- Backpressure: ADD 0x01+0x02, rsp_ready low for 3 cycles:
  - rsp_valid held 1 and rsp_data held 0x03 throughout.
  - req_ready 0 throughout; completes on the cycle rsp_ready rises.
- Reset asserted one cycle while in S_EXEC:
  - Next cycle: state S_IDLE, req_ready 1, rsp_valid 0, bus Z.
  - A following ADD 0x07+0x08 returns 0x0F with normal latency.
- Back-to-back with req_valid held high: two requests (0x01+0x01, 0x02+0x03) accepted 6 cycles apart, returning 0x02 and 0x05 in order.
